// File: rtl/encode_pkg.sv
// Shared constants and helpers for the FrodoKEM message encoder.
// Holds the per-security-level message length, bits per entry (B) and
// entry precision (D), the matrix geometry and the word packing factor.
package encode_pkg;

    localparam int unsigned L1_LEN_MU  = 128;
    localparam int unsigned L3_LEN_MU  = 192;
    localparam int unsigned L5_LEN_MU  = 256;

    localparam int unsigned L1_B       = 2;
    localparam int unsigned L3_B       = 3;
    localparam int unsigned L5_B       = 4;

    localparam int unsigned L1_D       = 15;
    localparam int unsigned L3_D       = 16;
    localparam int unsigned L5_D       = 16;

    localparam int unsigned L5_WIDTH_Q = 16;
    localparam int unsigned L5_MBAR    = 8;
    localparam int unsigned L5_NBAR    = 8;
    localparam int unsigned T_DECODE   = 4;

    typedef enum logic [1:0] {
        LEVEL1 = 2'd0,
        LEVEL3 = 2'd1,
        LEVEL5 = 2'd2
    } level_e;

    // Unrecognised level codes fall back to level 1.
    function automatic level_e decode_level(input logic [2:0] sec);
        case (sec)
            3'd3:    return LEVEL3;
            3'd5:    return LEVEL5;
            default: return LEVEL1;
        endcase
    endfunction

    // Reverse the bit order inside every byte: r[8v+w] = mu[8v+7-w].
    function automatic logic [L5_LEN_MU-1:0] byte_bitrev(input logic [L5_LEN_MU-1:0] mu);
        logic [L5_LEN_MU-1:0] r;
        r = '0;
        for (int v = 0; v < int'(L5_LEN_MU / 8); v++) begin
            for (int w = 0; w < 8; w++) begin
                r[8*v+w] = mu[8*v+7-w];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/encode_lane.sv
// Combinational chunk-to-entry mapper for one lane of an encoded word.
// Computes the entry for all three security levels and selects by level.
//   i_mu_r  : byte-bit-reversed message
//   i_level : decoded security level
//   i_word  : word (memory address) being produced
//   o_entry : B message bits, bit-reversed, placed just below bit D
module encode_lane
    import encode_pkg::*;
#(
    parameter int unsigned LANE   = 0,
    parameter int unsigned T      = T_DECODE,
    parameter int unsigned WORD_W = 4
) (
    input  logic [L5_LEN_MU-1:0]  i_mu_r,
    input  level_e                i_level,
    input  logic [WORD_W-1:0]     i_word,
    output logic [L5_WIDTH_Q-1:0] o_entry
);

    logic [31:0]           word;
    logic [31:0]           off1, off3, off5;
    logic [L1_B-1:0]       c1, r1;
    logic [L3_B-1:0]       c3, r3;
    logic [L5_B-1:0]       c5, r5;
    logic [L5_WIDTH_Q-1:0] e1, e3, e5;

    always_comb begin
        word = 32'(i_word);
        // Word 0 takes the most significant chunks of the message.
        off1 = L1_LEN_MU - (word + 32'd1) * T * L1_B + LANE * L1_B;
        off3 = L3_LEN_MU - (word + 32'd1) * T * L3_B + LANE * L3_B;
        off5 = L5_LEN_MU - (word + 32'd1) * T * L5_B + LANE * L5_B;

        c1 = L1_B'(i_mu_r >> off1);
        c3 = L3_B'(i_mu_r >> off3);
        c5 = L5_B'(i_mu_r >> off5);

        r1 = '0;
        r3 = '0;
        r5 = '0;
        for (int k = 0; k < int'(L1_B); k++) r1[k] = c1[L1_B-1-k];
        for (int k = 0; k < int'(L3_B); k++) r3[k] = c3[L3_B-1-k];
        for (int k = 0; k < int'(L5_B); k++) r5[k] = c5[L5_B-1-k];

        e1 = L5_WIDTH_Q'(r1) << (L1_D - L1_B);
        e3 = L5_WIDTH_Q'(r3) << (L3_D - L3_B);
        e5 = L5_WIDTH_Q'(r5) << (L5_D - L5_B);

        case (i_level)
            LEVEL3:  o_entry = e3;
            LEVEL5:  o_entry = e5;
            default: o_entry = e1;
        endcase
    end

endmodule

// File: rtl/encode.sv
// FrodoKEM message encoder: latches mu on start and writes the 8x8 encoded
// matrix to k_mat, T_ENCODE entries per word, one word per cycle.
// Optional feature macro ENCODE_ADD_EN: adds a v_mat read port and writes
// (v + entry) mod q instead of the bare entry, one cycle later.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_start          : start pulse, accepted only when idle
//   i_sec_level      : 1, 3 or 5 (anything else acts as 1)
//   i_mu             : message, sampled on the accepted start
//   o_k_mat*         : write data / enable / address
//   o_v_mat_en/addr  : read request (ENCODE_ADD_EN only)
//   i_v_mat          : read data, one cycle after request (ENCODE_ADD_EN only)
//   o_busy, o_done   : busy flag, one-cycle completion pulse
module encode
    import encode_pkg::*;
#(
    parameter int unsigned T_ENCODE = T_DECODE,
    parameter int unsigned WIDTH_Q  = L5_WIDTH_Q,
    parameter int unsigned NUM_COEF = L5_MBAR * L5_NBAR,
    localparam int unsigned N_WORDS = NUM_COEF / T_ENCODE,
    localparam int unsigned ADDR_W  = $clog2(N_WORDS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [2:0]                  i_sec_level,
    input  logic [L5_LEN_MU-1:0]        i_mu,
`ifdef ENCODE_ADD_EN
    output logic                        o_v_mat_en,
    output logic [ADDR_W-1:0]           o_v_mat_addr,
    input  logic [T_ENCODE*WIDTH_Q-1:0] i_v_mat,
`endif
    output logic [T_ENCODE*WIDTH_Q-1:0] o_k_mat,
    output logic                        o_k_mat_we,
    output logic [ADDR_W-1:0]           o_k_mat_addr,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ENC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

    logic [1:0]                  state_q, state_d;
    logic [L5_LEN_MU-1:0]        mu_q, mu_d;
    level_e                      level_q, level_d;
    logic                        we_q, we_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [T_ENCODE*WIDTH_Q-1:0] ent_q, ent_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic [L5_LEN_MU-1:0]        src_mu_r;
    level_e                      src_level;
    logic [ADDR_W-1:0]           src_word;
    logic [T_ENCODE*WIDTH_Q-1:0] word_ent;

`ifdef ENCODE_ADD_EN
    logic                        rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]           rd_addr_q, rd_addr_d;
    logic [WIDTH_Q-1:0]          lane_sum;

    // Entries are produced for the word being read; the sum is formed when
    // the read data returns, alongside the registered write strobe.
    always_comb begin
        src_mu_r  = byte_bitrev(mu_q);
        src_level = level_q;
        src_word  = rd_addr_q;
    end
`else
    // Word 0 is computed straight from the inputs on the accepting edge so
    // the first write appears the cycle after start.
    always_comb begin
        if (state_q == S_IDLE) begin
            src_mu_r  = byte_bitrev(i_mu);
            src_level = decode_level(i_sec_level);
            src_word  = '0;
        end else begin
            src_mu_r  = byte_bitrev(mu_q);
            src_level = level_q;
            src_word  = addr_q + ADDR_W'(1);
        end
    end
`endif

    for (genvar ii = 0; ii < T_ENCODE; ii++) begin : g_lane
        encode_lane #(
            .LANE   (ii),
            .T      (T_ENCODE),
            .WORD_W (ADDR_W)
        ) u_lane (
            .i_mu_r  (src_mu_r),
            .i_level (src_level),
            .i_word  (src_word),
            .o_entry (word_ent[ii*WIDTH_Q +: WIDTH_Q])
        );
    end

    always_comb begin
        state_d = state_q;
        mu_d    = mu_q;
        level_d = level_q;
        we_d    = we_q;
        addr_d  = addr_q;
        ent_d   = ent_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef ENCODE_ADD_EN
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_ENC;
                    mu_d    = i_mu;
                    level_d = decode_level(i_sec_level);
                    busy_d  = 1'b1;
`ifdef ENCODE_ADD_EN
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
`else
                    we_d    = 1'b1;
                    addr_d  = '0;
                    ent_d   = word_ent;
`endif
                end
            end
            S_ENC: begin
`ifdef ENCODE_ADD_EN
                we_d   = rd_en_q;
                addr_d = rd_addr_q;
                ent_d  = rd_en_q ? word_ent : '0;
                if (rd_en_q) begin
                    if (rd_addr_q == LAST) begin
                        rd_en_d   = 1'b0;
                        rd_addr_d = '0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
                if (we_q && (addr_q == LAST)) begin
                    state_d = S_DONE;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    ent_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
`else
                if (addr_q == LAST) begin
                    state_d = S_DONE;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    ent_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    ent_d  = word_ent;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mu_q    <= '0;
            level_q <= LEVEL1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ent_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ENCODE_ADD_EN
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mu_q    <= mu_d;
            level_q <= level_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ent_q   <= ent_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ENCODE_ADD_EN
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
`endif
        end
    end

`ifdef ENCODE_ADD_EN
    assign o_v_mat_en   = rd_en_q;
    assign o_v_mat_addr = rd_addr_q;

    // Level 1 has q = 2^15, so the sum drops bit 15; levels 3/5 wrap at 2^16.
    always_comb begin
        o_k_mat  = '0;
        lane_sum = '0;
        if (we_q) begin
            for (int ii = 0; ii < int'(T_ENCODE); ii++) begin
                lane_sum = ent_q[ii*WIDTH_Q +: WIDTH_Q] + i_v_mat[ii*WIDTH_Q +: WIDTH_Q];
                if (level_q == LEVEL1) lane_sum[WIDTH_Q-1] = 1'b0;
                o_k_mat[ii*WIDTH_Q +: WIDTH_Q] = lane_sum;
            end
        end
    end
`else
    assign o_k_mat = ent_q;
`endif

    assign o_k_mat_we   = we_q;
    assign o_k_mat_addr = addr_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_encode.sv
module tb_encode;

`ifdef ENCODE_ADD_EN
    localparam int WLAT = 2;
`else
    localparam int WLAT = 1;
`endif

    localparam logic [255:0] P1 = {128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF,
                                   128'h01234567_89ABCDEF_FEDCBA98_76543210};
    localparam logic [255:0] P3 = {64'hFFFFFFFF_FFFFFFFF,
                                   192'hA5A55A5A_0F0FF0F0_13579BDF_2468ACE0_C3C33C3C_84211248};
    localparam logic [255:0] P5 = 256'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0_DEADBEEFCAFEF00D_0011223344556677;

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } exp_t;

    logic         clk, rst, start;
    logic [2:0]   sec;
    logic [255:0] mu;
    logic [63:0]  k_mat;
    logic         we, busy, done;
    logic [3:0]   addr;
`ifdef ENCODE_ADD_EN
    logic         v_en;
    logic [3:0]   v_addr;
    logic [63:0]  v_mat;
    logic [63:0]  vmem [16];
`endif

    exp_t         exp_q[$];
    logic [63:0]  mem [16];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           t0, wr_cnt, done_cnt, first_wr_rel, done_rel;
    logic         busy_at_done;
    logic         sb_en;

    encode dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_sec_level  (sec),
        .i_mu         (mu),
`ifdef ENCODE_ADD_EN
        .o_v_mat_en   (v_en),
        .o_v_mat_addr (v_addr),
        .i_v_mat      (v_mat),
`endif
        .o_k_mat      (k_mat),
        .o_k_mat_we   (we),
        .o_k_mat_addr (addr),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

`ifdef ENCODE_ADD_EN
    always @(posedge clk) if (v_en) v_mat <= vmem[v_addr];
`endif

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: records writes and pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (we) begin
            wr_cnt++;
            mem[addr] = k_mat;
            if (first_wr_rel < 0) first_wr_rel = cyc - t0;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_extra: unexpected write addr %0d data %0h", addr, k_mat);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word", {addr, k_mat}, {e.addr, e.data});
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_rel     = cyc - t0;
            busy_at_done = busy;
        end
    end

    task automatic push_word(input int a, input logic [63:0] d);
        exp_t e;
        e.addr = 4'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_all(input logic [63:0] d);
        for (int a = 0; a < 16; a++) push_word(a, d);
    endtask

    task automatic start_enc(input logic [2:0] s, input logic [255:0] m);
        @(posedge clk); #1;
        sec = s; mu = m; start = 1'b1;
        t0 = cyc; wr_cnt = 0; done_cnt = 0; first_wr_rel = -1; done_rel = -1;
        busy_at_done = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", 256'(busy), 256'(1));
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        if (done_cnt == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no o_done within 60 cycles, required one");
        end else begin
            check("done_cycle", 256'(done_rel), 256'(WLAT + 16));
            check("first_write_cycle", 256'(first_wr_rel), 256'(WLAT));
            check("write_count", 256'(wr_cnt), 256'(16));
            check("busy_at_done", 256'(busy_at_done), 256'(0));
            check("sb_drained", 256'(exp_q.size()), 256'(0));
        end
    endtask

    task automatic run_enc(input logic [2:0] s, input logic [255:0] m);
        start_enc(s, m);
        wait_done();
    endtask

    // Decode the captured memory back to mu and compare with the message.
    task automatic rt_check(input string nm, input int b, input int d, input int len,
                            input logic [255:0] m);
        logic [255:0] mr, rec, req;
        logic [15:0]  e;
        int           off, stray;
        mr = '0; rec = '0; req = '0; stray = 0;
        for (int a = 0; a < 16; a++) begin
            for (int ii = 0; ii < 4; ii++) begin
                e   = mem[a][ii*16 +: 16];
                off = len - (a + 1) * 4 * b + ii * b;
                for (int k = 0; k < 16; k++) if (e[k] && (k < d - b || k >= d)) stray++;
                for (int k = 0; k < b; k++) mr[off + k] = e[d - 1 - k];
            end
        end
        for (int v = 0; v < 32; v++)
            for (int w = 0; w < 8; w++) rec[8*v+w] = mr[8*v+7-w];
        for (int i = 0; i < len; i++) req[i] = m[i];
        check(nm, rec, req);
        check({nm, "_stray_bits"}, 256'(stray), 256'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sec = 3'd0; mu = '0; sb_en = 1'b1;
        t0 = 0; wr_cnt = 0; done_cnt = 0; first_wr_rel = -1; done_rel = -1;
        busy_at_done = 1'b0;
`ifdef ENCODE_ADD_EN
        v_mat = '0;
        for (int a = 0; a < 16; a++) vmem[a] = '0;
`endif
        #3;
        check("rst_we", 256'(we), 256'(0));
        check("rst_addr", 256'(addr), 256'(0));
        check("rst_data", 256'(k_mat), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Level 5, zero message.
        push_all(64'h0);
        run_enc(3'd5, 256'h0);

        // Level 5, LSB set: only word 15 lane 1.
        for (int a = 0; a < 16; a++) push_word(a, (a == 15) ? 64'h0000_0000_1000_0000 : 64'h0);
        run_enc(3'd5, 256'h1);

        // All-ones at each level; level code 7 acts as level 1.
        push_all(64'h6000_6000_6000_6000);
        run_enc(3'd1, '1);
        push_all(64'hE000_E000_E000_E000);
        run_enc(3'd3, '1);
        push_all(64'h6000_6000_6000_6000);
        run_enc(3'd7, '1);
        push_all(64'hF000_F000_F000_F000);
        run_enc(3'd5, '1);

        // Level 5, top byte 0x01: word 0 lane 3.
        for (int a = 0; a < 16; a++) push_word(a, (a == 0) ? 64'h1000_0000_0000_0000 : 64'h0);
        run_enc(3'd5, {8'h01, 248'h0});

        // Round trip through a decode model.
        sb_en = 1'b0;
        run_enc(3'd1, P1);
        rt_check("rt_l1", 2, 15, 128, P1);
        run_enc(3'd3, P3);
        rt_check("rt_l3", 3, 16, 192, P3);
        run_enc(3'd5, P5);
        rt_check("rt_l5", 4, 16, 256, P5);
        sb_en = 1'b1;

        // Start during busy and input changes after start are ignored.
        push_all(64'h6000_6000_6000_6000);
        start_enc(3'd1, '1);
        mu = '0; sec = 3'd5;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; mu = 256'h1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("no_restart_writes", 256'(wr_cnt), 256'(16));

        // Reset on cycle 8 aborts the encode.
        sb_en = 1'b0;
        start_enc(3'd5, '1);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_we", 256'(we), 256'(0));
        check("abort_addr", 256'(addr), 256'(0));
        check("abort_data", 256'(k_mat), 256'(0));
        check("abort_busy", 256'(busy), 256'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("abort_writes", 256'(wr_cnt), 256'(8 - WLAT));
        check("abort_no_done", 256'(done_cnt), 256'(0));
        sb_en = 1'b1;

`ifdef ENCODE_ADD_EN
        // Level 1 addition wraps at 2^15.
        for (int a = 0; a < 16; a++) vmem[a] = 64'h7FFF_7FFF_7FFF_7FFF;
        push_all(64'h5FFF_5FFF_5FFF_5FFF);
        run_enc(3'd1, '1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
